// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with frame-synchronous value updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_scan_ctrl #(
  parameter int DIV = 100000,
  parameter int GAP = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] val,
  input  logic        val_load,
  output logic        val_ack,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [4:0]  n,
  output logic        dp_n,
  output logic        frame_done
);

  typedef enum logic {DRIVE, BLANK} st_t;

  localparam int MX = (DIV > GAP) ? DIV : GAP;
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;
  localparam logic [CW-1:0] DLAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GLAST = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam bit NOGAP = (GAP == 0);

  st_t            st;
  logic [1:0]     idx;
  logic [CW-1:0]  cnt;
  logic [15:0]    shadow;
  logic [15:0]    staging;
  logic           pending;

  logic           dlast;
  logic           blast;
  logic           bnd;
  logic [3:0]     vis;
  logic [3:0]     oh;
  logic [3:0]     nib;

  // Terminal-count decode and frame boundary (idx wrapping 3 -> 0)
  always_comb begin
    dlast = (st == DRIVE) && (cnt == DLAST);
    blast = (st == BLANK) && (cnt == GLAST);
    bnd   = (idx == 2'd3) && ((dlast && NOGAP) || blast);
    oh    = 4'b0001 << idx;
    nib   = shadow[{idx, 2'b00} +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Hide digits above the most significant nonzero nibble; digit 0 always shows
  always_comb begin
    vis[0] = 1'b1;
    vis[1] = |shadow[15:4];
    vis[2] = |shadow[15:8];
    vis[3] = |shadow[15:12];
  end
`else
  assign vis = 4'b1111;
`endif

  // Scan sequencer plus staging/shadow value pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= DRIVE;
      idx     <= 2'd0;
      cnt     <= '0;
      shadow  <= '0;
      staging <= '0;
      pending <= 1'b0;
    end else begin
      if (st == DRIVE) begin
        if (dlast) begin
          cnt <= '0;
          if (NOGAP) idx <= idx + 2'd1;
          else       st  <= BLANK;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        if (blast) begin
          st  <= DRIVE;
          idx <= idx + 2'd1;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (bnd && pending) shadow <= staging;
      if (val_load) begin
        staging <= val;
        pending <= 1'b1;
      end else if (bnd) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered display outputs, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      n          <= 5'd0;
      dp_n       <= 1'b1;
      val_ack    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      val_ack    <= bnd && pending;
      frame_done <= bnd;
      n          <= {1'b0, nib};
      if (st == DRIVE) begin
        an   <= ~(oh & digit_en & vis);
        dp_n <= ~dp_in[idx];
      end else begin
        an   <= 4'b1111;
        dp_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl with DIV=4, GAP=2.
// Table-driven first frames plus directed multi-cycle sequences.
module tb_hex_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] val;
  logic        val_load;
  logic        val_ack;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [4:0]  n;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hex_scan_ctrl #(.DIV(4), .GAP(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .val        (val),
    .val_load   (val_load),
    .val_ack    (val_ack),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .an         (an),
    .n          (n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  typedef struct {
    logic        ld;
    logic [15:0] v;
    logic [3:0]  en;
    logic [3:0]  an;
    logic [4:0]  n;
    logic        dpn;
    logic        ack;
    logic        fd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int cnt, input logic ld, input logic [15:0] v,
                     input logic [3:0] en, input logic [3:0] a,
                     input logic [4:0] nn, input logic dpn,
                     input logic ack, input logic fd);
    vec_t r;
    r.ld = ld; r.v = v; r.en = en; r.an = a;
    r.n = nn; r.dpn = dpn; r.ack = ack; r.fd = fd;
    for (int i = 0; i < cnt; i++) tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until frame_done is seen; counts val_ack pulses on the way
  task automatic wait_fd(output int acks);
    int k;
    acks = 0;
    k = 0;
    do begin
      step();
      if (val_ack) acks++;
      k++;
    end while (!frame_done && k < 100);
    chk("wait_fd_timeout", 16'(frame_done), 16'd1);
  endtask

  initial begin
    int acks;
    logic bad;
    logic [3:0] low;

    rst_n = 1'b0; val = '0; val_load = 1'b0;
    dp_in = 4'b0100; digit_en = 4'hF;

    // First frame after reset with a mid-frame load of 1A2F
    add(2, 0, 16'h0000, 4'hF, 4'hE, 5'h00, 1, 0, 0);
    add(1, 1, 16'h1A2F, 4'hF, 4'hE, 5'h00, 1, 0, 0);
    add(1, 0, 16'h0000, 4'hF, 4'hE, 5'h00, 1, 0, 0);
    add(2, 0, 16'h0000, 4'hF, 4'hF, 5'h00, 1, 0, 0);
    add(4, 0, 16'h0000, 4'hF, 4'hD, 5'h00, 1, 0, 0);
    add(2, 0, 16'h0000, 4'hF, 4'hF, 5'h00, 1, 0, 0);
    add(4, 0, 16'h0000, 4'hF, 4'hB, 5'h00, 0, 0, 0);
    add(2, 0, 16'h0000, 4'hF, 4'hF, 5'h00, 1, 0, 0);
    add(4, 0, 16'h0000, 4'hF, 4'h7, 5'h00, 1, 0, 0);
    add(1, 0, 16'h0000, 4'hF, 4'hF, 5'h00, 1, 0, 0);
    add(1, 0, 16'h0000, 4'hF, 4'hF, 5'h00, 1, 1, 1);
    add(4, 0, 16'h0000, 4'hF, 4'hE, 5'h0F, 1, 0, 0);
    add(2, 0, 16'h0000, 4'hF, 4'hF, 5'h0F, 1, 0, 0);
    add(2, 0, 16'h0000, 4'hD, 4'hF, 5'h02, 1, 0, 0);
    add(2, 0, 16'h0000, 4'hF, 4'hD, 5'h02, 1, 0, 0);

    step(); step();
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_n_code", 16'(n), 16'h0);
    chk("rst_dpn", 16'(dp_n), 16'h1);
    chk("rst_ack_fd", 16'({val_ack, frame_done}), 16'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      val_load = tbl[i].ld;
      val = tbl[i].v;
      digit_en = tbl[i].en;
      step();
      chk($sformatf("vec%0d", i),
          16'({an, n, dp_n, val_ack, frame_done}),
          16'({tbl[i].an, tbl[i].n, tbl[i].dpn, tbl[i].ack, tbl[i].fd}));
    end
    val_load = 1'b0;

    // Two loads in one frame: single ack, latest value wins
    val = 16'h1111; val_load = 1'b1; step();
    val_load = 1'b0; step();
    val = 16'h2222; val_load = 1'b1; step();
    val_load = 1'b0;
    wait_fd(acks);
    chk("double_load_acks", 16'(acks), 16'd1);
    chk("double_load_ack_with_fd", 16'(val_ack), 16'd1);
    bad = 1'b0;
    for (int i = 0; i < 23; i++) begin
      step();
      if (n !== 5'h02) bad = 1'b1;
    end
    chk("double_load_shows_2222", 16'(bad), 16'd0);

    // Load in the boundary cycle commits one frame later
    val = 16'h3333; val_load = 1'b1; step();
    val_load = 1'b0;
    chk("bnd_load_fd", 16'(frame_done), 16'd1);
    chk("bnd_load_no_ack", 16'(val_ack), 16'd0);
    bad = 1'b0;
    for (int i = 0; i < 23; i++) begin
      step();
      if (n !== 5'h02 || val_ack) bad = 1'b1;
    end
    chk("bnd_load_held_old", 16'(bad), 16'd0);
    step();
    chk("bnd_load_late_ack", 16'({val_ack, frame_done}), 16'h3);
    step();
    chk("bnd_load_new_n", 16'(n), 16'h03);

    // Reset during digit 2 drive with a pending load
    val = 16'h4444; val_load = 1'b1; step();
    val_load = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("pre_rst_digit2", 16'(an), 16'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 16'(an), 16'hF);
    chk("async_rst_n", 16'(n), 16'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_an", 16'(an), 16'hE);
    acks = 0; bad = 1'b0;
    for (int i = 1; i < 24; i++) begin
      step();
      if (val_ack) acks++;
      if (n !== 5'h00) bad = 1'b1;
    end
    chk("post_rst_no_ack", 16'(acks), 16'd0);
    chk("post_rst_shadow0", 16'(bad), 16'd0);
    chk("post_rst_fd", 16'(frame_done), 16'd1);

`ifdef LEADING_ZERO_BLANK_EN
    val = 16'h0040; val_load = 1'b1; step();
    val_load = 1'b0;
    wait_fd(acks);
    low = 4'b0000;
    for (int i = 0; i < 24; i++) begin
      step();
      low = low | ~an;
    end
    chk("lzb_0040", 16'(low), 16'h3);
    val = 16'h0000; val_load = 1'b1; step();
    val_load = 1'b0;
    wait_fd(acks);
    low = 4'b0000;
    for (int i = 0; i < 24; i++) begin
      step();
      low = low | ~an;
    end
    chk("lzb_0000", 16'(low), 16'h1);
`else
    low = 4'b0000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 100000, giving the clk cycles each digit is driven.
REQ-002 The block SHALL have parameter GAP, default 1000, giving the all-anodes-off cycles between digits (0 = no gap).
REQ-003 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port val, input, 16 bits, four hex nibbles (digit k = val[4k+3:4k]).
REQ-006 The block SHALL have port val_load, input, 1 bit, a one-cycle request to display val.
REQ-007 The block SHALL have port val_ack, output, 1 bit, a one-cycle pulse when the requested value becomes visible.
REQ-008 The block SHALL have port dp_in, input, 4 bits, the per-digit decimal point (1 = lit).
REQ-009 The block SHALL have port digit_en, input, 4 bits, the per-digit enable.
REQ-010 The block SHALL have port an, output, 4 bits, the active-low anode selects.
REQ-011 The block SHALL have port n, output, 5 bits, the decoder code {1'b0, nibble} for the hex7seg input.
REQ-012 The block SHALL have port dp_n, output, 1 bit, the active-low decimal-point cathode.
REQ-013 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse at each frame boundary.

Function
REQ-014 The block SHALL hold a 2-bit digit index idx, a cycle counter cnt, and state DRIVE or BLANK.
REQ-015 In DRIVE, cnt SHALL count 0..DIV-1; at DIV-1 it SHALL go to BLANK with cnt=0, or go straight to DRIVE with idx+1 if GAP=0.
REQ-016 In BLANK, cnt SHALL count 0..GAP-1; at GAP-1 it SHALL go to DRIVE with idx=(idx+1) mod 4 and cnt=0.
REQ-017 A frame boundary SHALL be the cycle in which idx wraps from 3 to 0; frame_done SHALL pulse in the cycle after it.
REQ-018 All outputs SHALL be registered, lagging the state, idx and shadow registers by exactly 1 cycle.
REQ-019 In DRIVE, an SHALL equal ~(onehot(idx) & digit_en & vis), where vis is defined by REQ-029 or REQ-030.
REQ-020 In BLANK, an SHALL equal 4'b1111.
REQ-021 n SHALL equal {1'b0, shadow[4*idx+3:4*idx]}.
REQ-022 dp_n SHALL equal ~dp_in[idx] in DRIVE and 1 in BLANK.
REQ-023 When val_load=1, val SHALL be captured into staging and pending SHALL be set; the latest request SHALL overwrite any earlier pending one.
REQ-024 At a frame boundary with pending=1, shadow SHALL take staging, pending SHALL clear and val_ack SHALL pulse with frame_done.
REQ-025 If val_load coincides with a frame boundary, the boundary SHALL commit the old staging (if pending), the new val SHALL go to staging, and pending SHALL remain set until the next boundary.
REQ-026 A digit_en change SHALL affect an on the next registered update, with no wait for a frame boundary.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously hold: state=DRIVE, idx=0, cnt=0, shadow=0, staging=0, pending=0, an=4'b1111, n=0, dp_n=1, val_ack=0, frame_done=0.
REQ-028 After rst_n rises, digit 0 SHALL be driven from the first registered update; a reset mid-frame SHALL discard any pending load.

Configuration
REQ-029 With macro LEADING_ZERO_BLANK_EN defined, vis[k] SHALL be 0 for every digit above the most significant nonzero nibble of shadow, and vis[0] SHALL always be 1 (shadow=0 shows a single "0").
REQ-030 Without LEADING_ZERO_BLANK_EN, vis SHALL be 4'b1111.

Verification (DIV=4, GAP=2)
REQ-031 Release reset, digit_en=F -> an cycles E,E,E,E,F,F,D... with 6-cycle digit period; frame_done every 24 cycles.
REQ-032 val=16'h1A2F, val_load mid-frame -> n shows old shadow until boundary; then val_ack+frame_done pulse together, n sequence F,2,A,1.
REQ-033 Two val_load (16'h1111 then 16'h2222) in one frame -> a single val_ack; 16'h2222 is displayed.
REQ-034 val_load at boundary cycle -> committed at the following boundary, not this one.
REQ-035 With LEADING_ZERO_BLANK_EN, shadow=16'h0040 -> only an[0] and an[1] are ever low; shadow=0 -> only an[0] is low.
REQ-036 Assert rst_n low mid-DRIVE of digit 2 with pending=1 -> an=F immediately; after release, digit 0 is driven, shadow=0 and no val_ack.
